ifu_fetch_sequencer: RTL

//  Sequences the NPC program counter and the instruction-memory fetch handshake.

---
 rtl/ifu_fetch_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ifu_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one imem fetch at a time and
// presents the fetched word to decode on a valid/ready port, honouring EXU redirects.
module ifu_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4,
  output logic        id_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;

  logic        req_hs;
  logic [31:0] redirect_tgt;

  assign req_hs       = (state_q == S_REQ) && imem_req_ready;
  assign redirect_tgt = redirect_pc & ~32'h3;

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign id_valid       = (state_q == S_OUT);
  assign id_inst        = inst_q;
  assign id_pc          = pc_q;
  assign id_pcplus4     = pc_q + 32'd4;
  assign id_fault       = fault_q;
  assign pc             = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      inst_q  <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // The old address already went out; its response must be thrown away.
          if (req_hs) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end else if (req_hs) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          if (imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_rsp_err ? 32'h0 : imem_rsp_data;
            fault_d = imem_rsp_err;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (id_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

endmodule
